// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: command-side controller for the up/down counter.
// Moves the counter to a target, lets it settle, then verifies the landed value.
module cnt_seq_ctrl #(
    parameter int CNTR_WDTH  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNTR_WDTH-1:0] target,
    input  logic [CNTR_WDTH-1:0] count,
    input  logic                 ovrflw,
    output logic                 act,
    output logic                 up_dwn,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [CNTR_WDTH:0] REM_ONE = {{CNTR_WDTH{1'b0}}, 1'b1};
    localparam logic [SW-1:0]      SET_LD  = SW'(SETTLE_CYC - 1);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_RUN    = 5'b00010,
        S_SETTLE = 5'b00100,
        S_DONE   = 5'b01000,
        S_FAULT  = 5'b10000
    } state_t;

    state_t                 r_state;
    logic                   r_act;
    logic                   r_up;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [CNTR_WDTH-1:0]   r_tgt;
    logic [CNTR_WDTH:0]     r_rem;
    logic [SW-1:0]          r_set;

    state_t                 w_state;
    logic                   w_act;
    logic                   w_up;
    logic [CNTR_WDTH-1:0]   w_tgt;
    logic [CNTR_WDTH:0]     w_rem;
    logic [SW-1:0]          w_set;
    logic [CNTR_WDTH:0]     w_dist;

    // Unsigned distance between requested target and current count.
    always_comb begin
        if (target > count) begin
            w_dist = {1'b0, target} - {1'b0, count};
        end else begin
            w_dist = {1'b0, count} - {1'b0, target};
        end
    end

    // Next-state and next-output logic; overflow beats every other transition.
    always_comb begin
        w_state = r_state;
        w_act   = r_act;
        w_up    = r_up;
        w_tgt   = r_tgt;
        w_rem   = r_rem;
        w_set   = r_set;
        if (ovrflw) begin
            w_state = S_FAULT;
            w_act   = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    w_state = S_IDLE;
                    if (start) begin
                        w_tgt = target;
                        if (w_dist == '0) begin
                            w_state = S_DONE;
                        end else begin
                            w_rem   = w_dist;
                            w_up    = (target > count);
                            w_act   = 1'b1;
                            w_state = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    w_rem = r_rem - REM_ONE;
                    if (r_rem == REM_ONE) begin
                        w_act   = 1'b0;
                        w_set   = SET_LD;
                        w_state = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_set == '0) begin
                        w_state = (count == r_tgt) ? S_DONE : S_FAULT;
                    end else begin
                        w_set = r_set - 1'b1;
                    end
                end
                S_FAULT: begin
                    w_act = 1'b0;
                end
                default: begin
                    w_state = S_FAULT;
                    w_act   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; err is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_act   <= 1'b0;
            r_up    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tgt   <= '0;
            r_rem   <= '0;
            r_set   <= '0;
        end else begin
            r_state <= w_state;
            r_act   <= w_act;
            r_up    <= w_up;
            r_tgt   <= w_tgt;
            r_rem   <= w_rem;
            r_set   <= w_set;
            r_busy  <= (w_state == S_RUN) || (w_state == S_SETTLE);
            r_done  <= (w_state == S_DONE);
            r_err   <= r_err | (w_state == S_FAULT);
        end
    end

    assign act    = r_act;
    assign up_dwn = r_up;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: bench for cnt_seq_ctrl with an attached counter model.
// A schedule-based reference model is compared against the DUT every cycle.
module tb_cnt_seq_ctrl;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] target;
    logic [W-1:0] cnt;
    logic         ovrflw;
    logic         act;
    logic         up_dwn;
    logic         busy;
    logic         done;
    logic         err;

    logic         ovf_real;
    logic         force_ovf;

    int checks   = 0;
    int failures = 0;

    cnt_seq_ctrl #(.CNTR_WDTH(W), .SETTLE_CYC(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .count  (cnt),
        .ovrflw (ovrflw),
        .act    (act),
        .up_dwn (up_dwn),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ovrflw = ovf_real | force_ovf;

    // Counter being controlled: steps once per act-high edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            ovf_real <= 1'b0;
        end else if (act) begin
            if ((up_dwn && cnt == 4'd15) || (!up_dwn && cnt == 4'd0))
                ovf_real <= 1'b1;
            else
                cnt <= up_dwn ? cnt + 4'd1 : cnt - 4'd1;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a move accepted at edge n with distance d keeps act
    // high after edges n..n+d-1, busy through n+d+S-1, and verifies at n+d+S.
    int   m_e, m_n, m_d, m_end, m_done_at;
    bit   m_active, m_fault;
    logic m_up;
    logic [W-1:0] m_tgt;
    logic m_act, m_busy, m_done, m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_e = 0; m_n = 0; m_d = 0; m_end = 0; m_done_at = -1;
            m_active = 0; m_fault = 0; m_up = 0; m_tgt = '0;
            m_act = 0; m_busy = 0; m_done = 0; m_err = 0;
        end else begin
            m_e++;
            if (!m_fault && ovrflw) begin
                m_fault = 1;
            end else if (!m_fault) begin
                if (m_active && m_d > 0 && m_e == m_end) begin
                    if (cnt == m_tgt) m_done_at = m_e;
                    else m_fault = 1;
                end
                if (!m_fault && start && (!m_active || m_e > m_end)) begin
                    m_active = 1;
                    m_n   = m_e;
                    m_tgt = target;
                    m_d   = (target > cnt) ? int'(target) - int'(cnt)
                                           : int'(cnt) - int'(target);
                    if (m_d > 0) begin
                        m_up  = (target > cnt);
                        m_end = m_e + m_d + S;
                    end else begin
                        m_end     = m_e;
                        m_done_at = m_e;
                    end
                end
            end
            if (m_fault) begin
                m_act = 0; m_busy = 0; m_done = 0; m_err = 1;
            end else begin
                m_act  = m_active && m_e >= m_n && m_e < m_n + m_d;
                m_busy = m_active && m_d > 0 && m_e >= m_n && m_e < m_n + m_d + S;
                m_done = (m_e == m_done_at);
                m_err  = 0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("m_act",    int'(act),    int'(m_act));
            chk("m_up_dwn", int'(up_dwn), int'(m_up));
            chk("m_busy",   int'(busy),   int'(m_busy));
            chk("m_done",   int'(done),   int'(m_done));
            chk("m_err",    int'(err),    int'(m_err));
        end
    end

    // Length of the most recent act-low run that preceded an act rise.
    int low_run = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if (!act) begin
            low_run++;
        end else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        target = '0;
        force_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_act",  int'(act),    0);
        chk("rst_up",   int'(up_dwn), 0);
        chk("rst_busy", int'(busy),   0);
        chk("rst_done", int'(done),   0);
        chk("rst_err",  int'(err),    0);
    endtask

    task automatic move(input logic [W-1:0] t, input int exp_act,
                        input int exp_lat, input bit wait_first);
        int lat;
        int acts;
        bit got;
        if (wait_first) @(negedge clk);
        start = 1'b1;
        target = t;
        lat = 1;
        acts = 0;
        got = 0;
        while (!got && lat < 80) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (act) acts++;
            if (done) got = 1;
        end
        chk("done_seen",  int'(got), 1);
        chk("act_cycles", acts, exp_act);
        chk("latency",    lat, exp_lat);
        chk("count",      int'(cnt), int'(t));
        chk("err_clear",  int'(err), 0);
    endtask

    initial begin
        int acts;
        rst = 1'b0;
        start = 1'b0;
        target = '0;
        force_ovf = 1'b0;

        do_reset();
        move(4'd5, 5, 9, 1);
        chk("t1_up", int'(up_dwn), 1);

        move(4'd9, 4, 8, 1);
        move(4'd3, 6, 10, 1);
        chk("t2_up", int'(up_dwn), 0);

        move(4'd7, 4, 8, 1);
        move(4'd7, 0, 2, 1);

        do_reset();
        move(4'd15, 15, 19, 1);
        move(4'd0, 15, 19, 0);
        chk("t4_gap", last_gap, S + 1);
        chk("t4_ovf", int'(ovf_real), 0);

        do_reset();
        @(negedge clk);
        start = 1'b1;
        target = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        force_ovf = 1'b1;
        @(negedge clk);
        force_ovf = 1'b0;
        chk("t5_act", int'(act), 0);
        chk("t5_err", int'(err), 1);
        start = 1'b1;
        target = 4'd3;
        acts = 0;
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
            if (act) acts++;
        end
        chk("t5_no_act", acts, 0);
        chk("t5_sticky", int'(err), 1);

        do_reset();
        @(negedge clk);
        start = 1'b1;
        target = 4'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_act_pre", int'(act), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_act",  int'(act),  0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_err",  int'(err),  0);
        @(negedge clk);
        rst = 1'b1;
        move(4'd4, 4, 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
